mp3_keys_ctrl: RTL and testbench

MP3_KEYS_CTRL -- requirements
Module: mp3_keys_ctrl

---
 rtl/mp3_keys_ctrl_if.sv | 20 ++
 rtl/mp3_keys_ctrl.sv | 127 ++++++++++++
 tb/tb_mp3_keys_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mp3_keys_ctrl_if.sv
// Avalon-MM register bus plus interrupt line of the key controller.
// Master side drives address/strobes/writedata; slave returns registered readdata and irq.
interface mp3_keys_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/mp3_keys_ctrl.sv
// Debounced key scanner with press/release/long/repeat flags, W1C event registers and masked irq.
// Latency: 2 sync + DEBOUNCE_CYCLES to STATUS, 1-cycle reads, irq 1 cycle after a flag; no backpressure (zero-wait slave).
module mp3_keys_ctrl #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] keys_export,
  mp3_keys_ctrl_if.slave      avs
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = LONG_CYCLES + REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   REP_LAST  = HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0]   REP_LOAD  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_SAT  = HOLD_W'(HOLD_MAX);
  localparam logic [NUM_KEYS-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
  localparam logic [31:0]         REG_BITS  = {16'({NUM_KEYS{1'b1}}), 16'({NUM_KEYS{1'b1}})};

  logic [NUM_KEYS-1:0] sync_q1, sync_q2, sync_lvl, stable;
  logic [DB_W-1:0]     db_cnt   [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_cnt [NUM_KEYS];

  logic [NUM_KEYS-1:0] db_hit, press_ev, release_ev, long_ev, repeat_ev;
  logic [NUM_KEYS-1:0] press_q, release_q, long_q, repeat_q, mask_lo, mask_hi;
  logic [NUM_KEYS-1:0] clr_press, clr_release, clr_long, clr_repeat;
  logic                wr_edge, wr_hold, wr_mask;
  logic [31:0]         rd_word;
  logic                wd_unused;

  assign sync_lvl = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

  always_comb begin
    db_hit     = '0;
    press_ev   = '0;
    release_ev = '0;
    long_ev    = '0;
    repeat_ev  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_hit[i]     = (sync_lvl[i] != stable[i]) && (db_cnt[i] == DB_LAST);
      press_ev[i]   = db_hit[i] && sync_lvl[i];
      release_ev[i] = db_hit[i] && !sync_lvl[i];
      long_ev[i]    = stable[i] && (hold_cnt[i] == LONG_LAST);
      repeat_ev[i]  = (REPEAT_CYCLES > 0) && stable[i] && (hold_cnt[i] == REP_LAST);
    end
  end

  // Synchronizers reset to the idle level so a key held through reset debounces afresh.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q1 <= SYNC_IDLE;
      sync_q2 <= SYNC_IDLE;
      stable  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync_q1 <= keys_export;
      sync_q2 <= sync_q1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if ((sync_lvl[i] == stable[i]) || db_hit[i]) db_cnt[i] <= '0;
        else                                          db_cnt[i] <= db_cnt[i] + 1'b1;

        if (db_hit[i]) stable[i] <= sync_lvl[i];

        // Reload after a repeat keeps the counter cycling through the repeat window.
        if (!stable[i])                    hold_cnt[i] <= '0;
        else if (repeat_ev[i])             hold_cnt[i] <= REP_LOAD;
        else if (hold_cnt[i] != HOLD_SAT)  hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  assign wr_edge = avs.avs_write && (avs.avs_address == 2'd1);
  assign wr_hold = avs.avs_write && (avs.avs_address == 2'd2);
  assign wr_mask = avs.avs_write && (avs.avs_address == 2'd3);

  assign clr_press   = wr_edge ? avs.avs_writedata[NUM_KEYS-1:0] : '0;
  assign clr_release = wr_edge ? avs.avs_writedata[16 +: NUM_KEYS] : '0;
  assign clr_long    = wr_hold ? avs.avs_writedata[NUM_KEYS-1:0] : '0;
  assign clr_repeat  = wr_hold ? avs.avs_writedata[16 +: NUM_KEYS] : '0;
  assign wd_unused   = ^(avs.avs_writedata & ~REG_BITS);

  always_comb begin
    case (avs.avs_address)
      2'd0:    rd_word = 32'(stable);
      2'd1:    rd_word = {16'(release_q), 16'(press_q)};
      2'd2:    rd_word = {16'(repeat_q), 16'(long_q)};
      default: rd_word = {16'(mask_hi), 16'(mask_lo)};
    endcase
  end

  // Event sets are OR'd after the clear so a coincident W1C never loses an event.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      press_q          <= '0;
      release_q        <= '0;
      long_q           <= '0;
      repeat_q         <= '0;
      mask_lo          <= '0;
      mask_hi          <= '0;
      avs.avs_readdata <= '0;
      avs.irq          <= 1'b0;
    end else begin
      press_q   <= (press_q   & ~clr_press)   | press_ev;
      release_q <= (release_q & ~clr_release) | release_ev;
      long_q    <= (long_q    & ~clr_long)    | long_ev;
      repeat_q  <= (repeat_q  & ~clr_repeat)  | repeat_ev;
      if (wr_mask) begin
        mask_lo <= avs.avs_writedata[NUM_KEYS-1:0];
        mask_hi <= avs.avs_writedata[16 +: NUM_KEYS];
      end
      if (avs.avs_read) avs.avs_readdata <= rd_word;
      avs.irq <= |(((press_q | long_q) & mask_lo) | ((release_q | repeat_q) & mask_hi));
    end
  end

endmodule

// File: tb/tb_mp3_keys_ctrl.sv
// Directed spec scenarios plus randomized keys/bus traffic, checked every cycle against a reference model.
module tb_mp3_keys_ctrl;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 8;
  localparam logic [31:0] VALID = 32'h000F_000F;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [NK-1:0] keys = '1;

  mp3_keys_ctrl_if avs_if();

  mp3_keys_ctrl #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
    .REPEAT_CYCLES(RC), .ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .keys_export(keys),
    .avs(avs_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw delay line, mismatch run lengths, and press age since the key was accepted.
  logic [NK-1:0] m_s1, m_s2, m_stable;
  int            m_run [NK];
  int            m_age [NK];
  logic [31:0]   m_edge, m_hold, m_mask, m_rd;
  logic          m_irq;

  int            rise_t[$];
  int            exp_rise [5] = '{35, 43, 51, 59, 67};
  int            run_left [NK];
  logic          prev_irq;
  logic [31:0]   d;
  int            lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] set_e, set_h, clr_e, clr_h, rdv;
    logic        s;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_stable = '0;
      m_edge = '0; m_hold = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
      for (int k = 0; k < NK; k++) begin
        m_run[k] = 0;
        m_age[k] = 0;
      end
    end else begin
      case (avs_if.avs_address)
        2'd0:    rdv = 32'(m_stable);
        2'd1:    rdv = m_edge;
        2'd2:    rdv = m_hold;
        default: rdv = m_mask;
      endcase
      if (avs_if.avs_read) m_rd = rdv;
      m_irq = |((m_edge | m_hold) & m_mask);
      set_e = '0;
      set_h = '0;
      for (int k = 0; k < NK; k++) begin
        s = ~m_s2[k];
        if (m_stable[k]) begin
          if (m_age[k] == LC - 1) set_h[k] = 1'b1;
          if (m_age[k] >= LC - 1 + RC && ((m_age[k] - (LC - 1)) % RC) == 0) set_h[16 + k] = 1'b1;
          m_age[k]++;
        end else begin
          m_age[k] = 0;
        end
        if (s != m_stable[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            if (s) set_e[k] = 1'b1;
            else   set_e[16 + k] = 1'b1;
            m_stable[k] = s;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      clr_e = (avs_if.avs_write && avs_if.avs_address == 2'd1) ? (avs_if.avs_writedata & VALID) : 32'h0;
      clr_h = (avs_if.avs_write && avs_if.avs_address == 2'd2) ? (avs_if.avs_writedata & VALID) : 32'h0;
      m_edge = (m_edge & ~clr_e) | set_e;
      m_hold = (m_hold & ~clr_h) | set_h;
      if (avs_if.avs_write && avs_if.avs_address == 2'd3) m_mask = avs_if.avs_writedata & VALID;
      m_s2 = m_s1;
      m_s1 = keys;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("readdata", avs_if.avs_readdata, m_rd);
    check("irq", 32'(avs_if.irq), 32'(m_irq));
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] q);
    avs_if.avs_address = a;
    avs_if.avs_read    = 1'b1;
    tick();
    avs_if.avs_read    = 1'b0;
    q = avs_if.avs_readdata;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] v);
    avs_if.avs_address   = a;
    avs_if.avs_writedata = v;
    avs_if.avs_write     = 1'b1;
    tick();
    avs_if.avs_write     = 1'b0;
  endtask

  task automatic quiesce();
    keys = '1;
    repeat (10) tick();
    reg_write(2'd1, 32'hFFFF_FFFF);
    reg_write(2'd2, 32'hFFFF_FFFF);
    reg_write(2'd3, 32'h0);
  endtask

  initial begin
    avs_if.avs_address = 2'd0; avs_if.avs_read = 1'b0;
    avs_if.avs_write = 1'b0;   avs_if.avs_writedata = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), d);
      check("reset_reg", d, 32'h0);
    end
    check("reset_irq", 32'(avs_if.irq), 32'h0);

    // Short glitches never reach the debounce threshold.
    repeat (5) begin
      keys[0] = 1'b0; repeat (3) tick();
      keys[0] = 1'b1; repeat (3) tick();
    end
    repeat (6) tick();
    reg_read(2'd0, d); check("glitch_status", d, 32'h0);
    reg_read(2'd1, d); check("glitch_edge", d, 32'h0);
    check("glitch_irq", 32'(avs_if.irq), 32'h0);

    // Press latency, masked irq and W1C clearing.
    reg_write(2'd3, 32'h0000_0002);
    keys[1] = 1'b0;
    lat = 0;
    while (!avs_if.irq && lat < 30) begin
      tick();
      lat++;
    end
    check("irq_latency", lat, 7);
    reg_read(2'd0, d); check("press_status", d, 32'h2);
    reg_read(2'd1, d); check("press_edge", d, 32'h2);
    reg_write(2'd1, 32'h2);
    reg_read(2'd1, d); check("w1c_edge", d, 32'h0);
    check("w1c_irq", 32'(avs_if.irq), 32'h0);
    quiesce();

    // Long press with repeats on key2, observed through the repeat/release mask.
    reg_write(2'd3, 32'h0004_0000);
    keys[2] = 1'b0;
    prev_irq = 1'b0;
    for (int t = 1; t <= 75; t++) begin
      tick();
      avs_if.avs_write = 1'b0;
      if (t == 61) keys[2] = 1'b1;
      if (avs_if.irq && !prev_irq) begin
        rise_t.push_back(t);
        avs_if.avs_address   = 2'd2;
        avs_if.avs_writedata = 32'h0004_0000;
        avs_if.avs_write     = 1'b1;
      end
      prev_irq = avs_if.irq;
    end
    avs_if.avs_write = 1'b0;
    tick();
    check("repeat_count", rise_t.size(), 5);
    for (int j = 0; j < rise_t.size() && j < 5; j++) check("repeat_time", rise_t[j], exp_rise[j]);
    reg_read(2'd2, d); check("long_hold", d, 32'h0000_0004);
    reg_read(2'd1, d); check("release_edge", d, 32'h0004_0004);
    quiesce();

    // W1C coinciding with the press event keeps the bit.
    keys[0] = 1'b0;
    repeat (5) tick();
    reg_write(2'd1, 32'h1);
    reg_read(2'd1, d); check("w1c_race", d & 32'h1, 32'h1);
    quiesce();

    // Key held through reset, then reset mid-hold.
    keys[3] = 1'b0;
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    repeat (5) tick();
    reg_read(2'd1, d); check("held_press_early", d, 32'h0);
    reg_read(2'd1, d); check("held_press", d, 32'h8);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (25) tick();
    reg_read(2'd2, d); check("hold_after_rst_early", d, 32'h0);
    reg_read(2'd2, d); check("hold_after_rst", d, 32'h8);
    reg_read(2'd1, d); check("press_after_rst", d, 32'h8);
    quiesce();

    // Randomized traffic.
    for (int k = 0; k < NK; k++) run_left[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (run_left[k] == 0) begin
          keys[k] = ~keys[k];
          run_left[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 90));
        end else begin
          run_left[k]--;
        end
      end
      avs_if.avs_read      = ($urandom_range(0, 2) == 0);
      avs_if.avs_write     = ($urandom_range(0, 4) == 0);
      avs_if.avs_address   = 2'($urandom_range(0, 3));
      avs_if.avs_writedata = $urandom;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    avs_if.avs_read  = 1'b0;
    avs_if.avs_write = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
